// File: rtl/cache_victim_buf.sv
// cache_victim_buf: single-entry victim write-back buffer.
// Captures a dirty evicted cache line. Streams it to the bus one beat at a
// time, least significant beat first, and honours WBReady backpressure.
// Optional feature macro: VICTIM_SNOOP_EN. When defined, SnoopHit flags a
// pending fill whose line address matches the line being written back.
// When undefined, SnoopHit is tied low and no comparator is built.

module cache_victim_buf #(
    parameter int NUMWAYS = 4,
    parameter int PA_BITS = 32,
    parameter int LINELEN = 256,
    parameter int BEATLEN = 64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               FlushStage,
    input  logic               VictimValid,
    input  logic               VictimDirty,
    input  logic [NUMWAYS-1:0] VictimWay,
    input  logic [PA_BITS-1:0] VictimAdr,
    input  logic [LINELEN-1:0] VictimLine,
    output logic               BufReady,
    output logic               WBValid,
    input  logic               WBReady,
    output logic [PA_BITS-1:0] WBAdr,
    output logic [BEATLEN-1:0] WBData,
    output logic               WBLast,
    output logic [NUMWAYS-1:0] WBWay,
    input  logic [PA_BITS-1:0] SnoopAdr,
    output logic               SnoopHit
);

    localparam int NBEATS     = LINELEN / BEATLEN;
    localparam int BEAT_W     = $clog2(NBEATS);
    localparam int OFF_W      = $clog2(LINELEN / 8);
    localparam int BEAT_SHIFT = $clog2(BEATLEN / 8);
    localparam logic [PA_BITS-1:0] LINE_MASK = {PA_BITS{1'b1}} << OFF_W;
    localparam logic [BEAT_W-1:0]  LAST_BEAT = BEAT_W'(NBEATS - 1);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t               state_q, state_d;
    logic [BEAT_W-1:0]    beat_q,  beat_d;
    logic [PA_BITS-1:0]   adr_q,   adr_d;
    logic [LINELEN-1:0]   line_q,  line_d;
    logic [NUMWAYS-1:0]   way_q,   way_d;
    logic                 capture;

    // Next-state logic: capture a dirty victim in IDLE, then step through beats on each accepted transfer.
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        adr_d   = adr_q;
        line_d  = line_q;
        way_d   = way_q;
        capture = VictimValid & VictimDirty & ~FlushStage & (state_q == IDLE);
        case (state_q)
            IDLE: begin
                if (capture) begin
                    state_d = SEND;
                    beat_d  = '0;
                    adr_d   = VictimAdr & LINE_MASK;
                    line_d  = VictimLine;
                    way_d   = VictimWay;
                end
            end
            SEND: begin
                if (WBReady) begin
                    if (beat_q == LAST_BEAT) begin
                        state_d = IDLE;
                        beat_d  = '0;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                beat_d  = '0;
            end
        endcase
    end

    // Control registers; reset abandons any line in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
        end
    end

    // Captured line payload; only meaningful while sending, so it needs no reset.
    always_ff @(posedge clk) begin
        adr_q  <= adr_d;
        line_q <= line_d;
        way_q  <= way_d;
    end

    assign BufReady = (state_q == IDLE);
    assign WBValid  = (state_q == SEND);
    assign WBLast   = (state_q == SEND) && (beat_q == LAST_BEAT);
    assign WBData   = line_q[int'(beat_q) * BEATLEN +: BEATLEN];
    assign WBAdr    = adr_q + (PA_BITS'(beat_q) << BEAT_SHIFT);
    assign WBWay    = way_q;

`ifdef VICTIM_SNOOP_EN
    logic unused_snoop_offset;
    assign unused_snoop_offset = ^SnoopAdr[OFF_W-1:0];
    assign SnoopHit = (state_q == SEND) &&
                      (SnoopAdr[PA_BITS-1:OFF_W] == adr_q[PA_BITS-1:OFF_W]);
`else
    logic unused_snoop;
    assign unused_snoop = ^SnoopAdr;
    assign SnoopHit     = 1'b0;
`endif

endmodule
